// File: rtl/snake_frame_builder_if.sv
// Bundles the frame-builder handshake, snake snapshot inputs, status flags and
// the display row-read port into one interface.
// master: the move stage / display scanner side; slave: the frame builder.
interface snake_frame_builder_if #(
  parameter int SEG_W   = 8,
  parameter int MAX_SEG = 225,
  parameter int GRID    = 16
);

  logic                     start;
  logic [SEG_W*MAX_SEG-1:0] snake_vec;
  logic [7:0]               snake_len;
  logic [3:0]               food_x;
  logic [3:0]               food_y;
  logic [3:0]               row_addr;
  logic [GRID-1:0]          row_data;
  logic                     busy;
  logic                     frame_valid;
  logic                     collide;
  logic                     eat;

  modport master (
    output start,
    output snake_vec,
    output snake_len,
    output food_x,
    output food_y,
    output row_addr,
    input  row_data,
    input  busy,
    input  frame_valid,
    input  collide,
    input  eat
  );

  modport slave (
    input  start,
    input  snake_vec,
    input  snake_len,
    input  food_x,
    input  food_y,
    input  row_addr,
    output row_data,
    output busy,
    output frame_valid,
    output collide,
    output eat
  );

endinterface

// File: rtl/snake_frame_builder.sv
// Snake frame builder.
// On a start pulse the packed segment vector is snapshotted, then walked one
// segment per clock to paint a 16x16 occupancy bitmap into the back buffer.
// The food cell is overlaid afterwards, head/body collision and head/food hit
// are resolved, and the back buffer is swapped to the front so the display
// scanner only ever sees complete frames.
module snake_frame_builder #(
  parameter int SEG_W   = 8,
  parameter int MAX_SEG = 225,
  parameter int GRID    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  snake_frame_builder_if.slave  bus
);

  localparam int VEC_W = SEG_W * MAX_SEG;

  // Frame build sequencing: wait for start, walk the segments, then finish
  // with an overlay cycle followed by a swap cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Snapshot of the request taken on the start edge.
  logic [VEC_W-1:0] vec_q;
  logic [7:0]       len_q;
  logic [7:0]       head_q;
  logic [3:0]       food_x_q;
  logic [3:0]       food_y_q;

  // Scan bookkeeping.
  logic [7:0] k_q;
  logic       coll_acc;
  logic       done_step;

  // Two complete bitmaps; front_sel picks the one the display reads.
  logic [1:0][GRID-1:0][GRID-1:0] bitmap;
  logic                           front_sel;
  logic                           back_sel;

  // Registered status outputs.
  logic frame_valid_q;
  logic collide_q;
  logic eat_q;

  // Control strobes decoded from the current state.
  logic busy_c;
  logic capture;
  logic scan_en;
  logic overlay_en;
  logic swap_en;

  // Request-side helpers.
  logic [7:0]  len_clamped;
  logic [7:0]  head_sel;
  logic [10:0] head_base;
  logic [7:0]  head_in;

  // Scan-side helpers.
  logic [10:0] seg_base;
  logic [7:0]  seg_cur;
  logic        last_seg;

  // A length beyond the slot count is treated as a full snake.
  assign len_clamped = (bus.snake_len > 8'(MAX_SEG)) ? 8'(MAX_SEG) : bus.snake_len;

  // The head is segment len-1; an empty snake points at slot 0 so the
  // part-select stays in range (the value is never used for eat then).
  assign head_sel  = (len_clamped == 8'd0) ? 8'd0 : (len_clamped - 8'd1);
  assign head_base = {head_sel, 3'b000};
  assign head_in   = bus.snake_vec[head_base +: SEG_W];

  // Segment k of the captured snapshot, and whether it is the head slot.
  assign seg_base = {k_q, 3'b000};
  assign seg_cur  = vec_q[seg_base +: SEG_W];
  assign last_seg = (k_q == (len_q - 8'd1));

  // The back buffer is always the one the display is not looking at.
  assign back_sel = ~front_sel;

  // State register; a reset pulse abandons any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: an empty snake skips straight to the finishing steps,
  // and DONE lingers for the overlay cycle before the swap cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (len_clamped == 8'd0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (last_seg) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (done_step) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output/strobe decode: start is only honoured in IDLE, so a start while
  // busy falls on the floor without being queued.
  always_comb begin
    busy_c     = 1'b0;
    capture    = 1'b0;
    scan_en    = 1'b0;
    overlay_en = 1'b0;
    swap_en    = 1'b0;
    unique case (state)
      IDLE: begin
        capture = bus.start;
      end
      SCAN: begin
        busy_c  = 1'b1;
        scan_en = 1'b1;
      end
      DONE: begin
        busy_c     = 1'b1;
        overlay_en = ~done_step;
        swap_en    = done_step;
      end
      default: begin
        busy_c = 1'b0;
      end
    endcase
  end

  // Datapath: snapshot on start, paint one segment per scan cycle, overlay the
  // food, then publish the bitmap together with the collide/eat verdicts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_q         <= '0;
      len_q         <= '0;
      head_q        <= '0;
      food_x_q      <= '0;
      food_y_q      <= '0;
      k_q           <= '0;
      coll_acc      <= 1'b0;
      done_step     <= 1'b0;
      front_sel     <= 1'b0;
      bitmap        <= '0;
      frame_valid_q <= 1'b0;
      collide_q     <= 1'b0;
      eat_q         <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;

      if (capture) begin
        vec_q            <= bus.snake_vec;
        len_q            <= len_clamped;
        head_q           <= head_in;
        food_x_q         <= bus.food_x;
        food_y_q         <= bus.food_y;
        k_q              <= 8'd0;
        coll_acc         <= 1'b0;
        done_step        <= 1'b0;
        bitmap[back_sel] <= '0;
      end

      if (scan_en) begin
        bitmap[back_sel][seg_cur[7:4]][seg_cur[3:0]] <= 1'b1;
        if (!last_seg && (seg_cur == head_q)) begin
          coll_acc <= 1'b1;
        end
        k_q <= k_q + 8'd1;
      end

      if (overlay_en) begin
        bitmap[back_sel][food_y_q][food_x_q] <= 1'b1;
        done_step <= 1'b1;
      end

      if (swap_en) begin
        front_sel     <= back_sel;
        frame_valid_q <= 1'b1;
        collide_q     <= coll_acc;
        eat_q         <= (len_q != 8'd0) && (head_q == {food_y_q, food_x_q});
        done_step     <= 1'b0;
      end
    end
  end

  assign bus.row_data    = bitmap[front_sel][bus.row_addr];
  assign bus.busy        = busy_c;
  assign bus.frame_valid = frame_valid_q;
  assign bus.collide     = collide_q;
  assign bus.eat         = eat_q;

endmodule

// File: tb/tb_snake_frame_builder.sv
// Bench for snake_frame_builder: directed frames with hand-computed bitmaps
// and latencies, plus a cycle-by-cycle comparison against a behavioural model.
module tb_snake_frame_builder;

  typedef logic [15:0][15:0] frame_t;

  logic clk;
  logic reset;

  snake_frame_builder_if bus ();

  snake_frame_builder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] seg_list [$];

  // Behavioural model state.
  bit     m_pending   = 1'b0;
  int     m_rem       = 0;
  bit     m_fv        = 1'b0;
  bit     m_coll      = 1'b0;
  bit     m_eat       = 1'b0;
  frame_t m_front     = '0;
  frame_t m_pend_frame = '0;
  bit     m_pend_coll = 1'b0;
  bit     m_pend_eat  = 1'b0;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int clamp_len(input logic [7:0] l);
    return (l > 8'd225) ? 225 : int'(l);
  endfunction

  function automatic frame_t model_frame(input logic [1799:0] v, input int len,
                                         input logic [3:0] fy, input logic [3:0] fx);
    frame_t     f;
    logic [7:0] s;
    f = '0;
    for (int k = 0; k < len; k++) begin
      s = v[k*8 +: 8];
      f[s[7:4]][s[3:0]] = 1'b1;
    end
    f[fy][fx] = 1'b1;
    return f;
  endfunction

  function automatic bit model_collide(input logic [1799:0] v, input int len);
    logic [7:0] head;
    if (len < 2) return 1'b0;
    head = v[(len-1)*8 +: 8];
    for (int k = 0; k < len - 1; k++) begin
      if (v[k*8 +: 8] == head) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit model_eat(input logic [1799:0] v, input int len,
                                   input logic [3:0] fy, input logic [3:0] fx);
    if (len == 0) return 1'b0;
    return v[(len-1)*8 +: 8] == {fy, fx};
  endfunction

  // Model: an accepted start publishes its frame len+2 edges later; starts
  // arriving while a frame is pending are dropped.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pending <= 1'b0;
      m_rem     <= 0;
      m_fv      <= 1'b0;
      m_coll    <= 1'b0;
      m_eat     <= 1'b0;
      m_front   <= '0;
    end else begin
      m_fv <= 1'b0;
      if (m_pending) begin
        if (m_rem == 1) begin
          m_pending <= 1'b0;
          m_fv      <= 1'b1;
          m_front   <= m_pend_frame;
          m_coll    <= m_pend_coll;
          m_eat     <= m_pend_eat;
        end
        m_rem <= m_rem - 1;
      end else if (bus.start) begin
        m_pend_frame <= model_frame(bus.snake_vec, clamp_len(bus.snake_len), bus.food_y, bus.food_x);
        m_pend_coll  <= model_collide(bus.snake_vec, clamp_len(bus.snake_len));
        m_pend_eat   <= model_eat(bus.snake_vec, clamp_len(bus.snake_len), bus.food_y, bus.food_x);
        m_pending    <= 1'b1;
        m_rem        <= clamp_len(bus.snake_len) + 2;
      end
    end
  end

  // Every cycle, compare all DUT outputs with the model mid-period.
  always @(negedge clk) begin
    check_val("model_busy", bus.busy, m_pending);
    check_val("model_frame_valid", bus.frame_valid, m_fv);
    check_val("model_collide", bus.collide, m_coll);
    check_val("model_eat", bus.eat, m_eat);
    check_val($sformatf("model_row_data[%0d]", bus.row_addr), bus.row_data, m_front[bus.row_addr]);
  end

  // Place seg_list into the segment vector with the given length and food.
  task automatic load_frame(input logic [7:0] len, input logic [3:0] fy, input logic [3:0] fx);
    bus.snake_vec = '0;
    for (int k = 0; k < seg_list.size(); k++) begin
      bus.snake_vec[k*8 +: 8] = seg_list[k];
    end
    bus.snake_len = len;
    bus.food_y    = fy;
    bus.food_x    = fx;
  endtask

  // Pulse start for one cycle and measure edges until frame_valid.
  task automatic apply_stimulus(input int exp_edge);
    int n;
    bit found;
    @(posedge clk);
    #2 bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.frame_valid) found = 1'b1;
    end
    check_val("fv_latency", found ? n : 999, exp_edge);
  endtask

  // Sweep every display row against a literal frame, then the flags.
  task automatic check_output(input frame_t exp, input bit exp_coll, input bit exp_eat);
    for (int r = 0; r < 16; r++) begin
      @(posedge clk);
      #2 bus.row_addr = 4'(r);
      @(negedge clk);
      check_val($sformatf("row_data[%0d]", r), bus.row_data, exp[r]);
    end
    check_val("collide", bus.collide, exp_coll);
    check_val("eat", bus.eat, exp_eat);
  endtask

  // Safety net in case the DUT or bench stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    n_mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    frame_t exp;
    int     fv_count;
    int     fv_edge;

    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.snake_vec = '0;
    bus.snake_len = 8'd0;
    bus.food_x    = 4'd0;
    bus.food_y    = 4'd0;
    bus.row_addr  = 4'd0;

    // Reset state: all rows blank, all flags low.
    check_output('0, 1'b0, 1'b0);
    check_val("reset_busy", bus.busy, 1'b0);
    check_val("reset_frame_valid", bus.frame_valid, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;

    // Three-segment snake along row 1, food at (3,3).
    seg_list = '{8'h11, 8'h12, 8'h13};
    load_frame(8'd3, 4'd3, 4'd3);
    apply_stimulus(5);
    exp = '0;
    exp[1] = 16'h000E;
    exp[3] = 16'h0008;
    check_output(exp, 1'b0, 1'b0);

    // Head lands on the tail cell.
    seg_list = '{8'h22, 8'h23, 8'h33, 8'h32, 8'h22};
    load_frame(8'd5, 4'd2, 4'd3);
    apply_stimulus(7);
    exp = '0;
    exp[2] = 16'h000C;
    exp[3] = 16'h000C;
    check_output(exp, 1'b1, 1'b0);

    // Overlapping body cells without the head: no collision.
    seg_list = '{8'h61, 8'h61, 8'h62};
    load_frame(8'd3, 4'd0, 4'd0);
    apply_stimulus(5);
    exp = '0;
    exp[0] = 16'h0001;
    exp[6] = 16'h0006;
    check_output(exp, 1'b0, 1'b0);

    // Ten-segment scan with a second start mid-scan and a scrambled vector.
    seg_list = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
    load_frame(8'd10, 4'd9, 4'd9);
    @(posedge clk);
    #2 bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    bus.snake_vec = '1;
    @(posedge clk);
    @(posedge clk);
    #2 bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    fv_count = 0;
    fv_edge  = 0;
    for (int e = 4; e <= 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.frame_valid) begin
        fv_count++;
        fv_edge = e;
      end
    end
    check_val("ignored_start_fv_count", fv_count, 1);
    check_val("ignored_start_fv_edge", fv_edge, 12);
    exp = '0;
    exp[4] = 16'h03FF;
    exp[9] = 16'h0200;
    check_output(exp, 1'b0, 1'b0);

    // Oversized length clamps to 225 segments.
    seg_list = {};
    for (int k = 0; k < 225; k++) seg_list.push_back(8'(k));
    load_frame(8'd255, 4'd15, 4'd15);
    apply_stimulus(227);
    exp = '0;
    for (int r = 0; r < 14; r++) exp[r] = 16'hFFFF;
    exp[14] = 16'h0001;
    exp[15] = 16'h8000;
    check_output(exp, 1'b0, 1'b0);

    // Empty snake: only the food cell shows.
    seg_list = {};
    load_frame(8'd0, 4'd7, 4'd12);
    apply_stimulus(2);
    exp = '0;
    exp[7] = 16'h1000;
    check_output(exp, 1'b0, 1'b0);

    // Single-segment snake sitting on the food.
    seg_list = '{8'h57};
    load_frame(8'd1, 4'd5, 4'd7);
    apply_stimulus(3);
    exp = '0;
    exp[5] = 16'h0080;
    check_output(exp, 1'b0, 1'b1);

    // Reset in the middle of a scan aborts everything immediately.
    seg_list = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
    load_frame(8'd10, 4'd9, 4'd9);
    @(posedge clk);
    #2 bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    bus.row_addr = 4'd5;
    #1;
    check_val("abort_busy", bus.busy, 1'b0);
    check_val("abort_eat", bus.eat, 1'b0);
    check_val("abort_row_data[5]", bus.row_data, 16'h0000);
    check_output('0, 1'b0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    fv_count = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.frame_valid) fv_count++;
    end
    check_val("no_frame_without_start", fv_count, 0);

    // A fresh start after reset builds normally.
    seg_list = '{8'h11, 8'h12, 8'h13};
    load_frame(8'd3, 4'd3, 4'd3);
    apply_stimulus(5);
    exp = '0;
    exp[1] = 16'h000E;
    exp[3] = 16'h0008;
    check_output(exp, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
